// File: rtl/otp_i2c_pkg.sv
// Shared I2C definitions for the OTP controller: slave FSM states, bus constants
// and the default device address shared with the master model.
package otp_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV_ADDR  = 4'd1,
        DEV_ACK   = 4'd2,
        REG_ADDR  = 4'd3,
        REG_ACK   = 4'd4,
        WR_DATA   = 4'd5,
        WR_ACK    = 4'd6,
        RD_DATA   = 4'd7,
        RD_ACK    = 4'd8,
        WAIT_STOP = 4'd9
    } i2c_state_e;

    localparam logic       I2C_ACK      = 1'b0;
    localparam logic       I2C_NACK     = 1'b1;
    localparam logic       I2C_WRITE    = 1'b0;
    localparam logic       I2C_READ     = 1'b1;
    localparam logic [6:0] I2C_DEV_ADDR = 7'h0A;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one I2C line followed by rise/fall detection
// against the previous synchronized sample.
module i2c_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Idle bus level is high, so resetting to 1 avoids a phantom edge at reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            r_sync[0] <= i_din;
            for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  =  o_level & ~r_prev;
    assign o_fall  = ~o_level &  r_prev;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C slave that bridges bus transfers to a simple register file: address match,
// register pointer with auto-increment, write strobes and read fetches.
module i2c_slave_regif
    import otp_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = I2C_DEV_ADDR,
    parameter int         NUM_REGS    = 128,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       i2c_sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
    localparam logic [7:0] LAST_REG   = 8'(NUM_REGS - 1);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_scl (
        .i_clk   (clk_sys),
        .i_rst_n (rst_n),
        .i_din   (i2c_scl),
        .o_level (w_scl_lvl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sda (
        .i_clk   (clk_sys),
        .i_rst_n (rst_n),
        .i_din   (i2c_sda),
        .o_level (w_sda_lvl),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl_lvl;
    assign w_stop  = w_sda_rise & w_scl_lvl;

    i2c_state_e r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shreg, w_shreg_nxt;
    logic [7:0] r_ptr, w_ptr_nxt;
    logic [7:0] r_wdata, w_wdata_nxt;
    logic       r_oe, w_oe_nxt;
    logic       r_wr_en, w_wr_en_nxt;
    logic       r_rd_en, w_rd_en_nxt;
    logic       r_cap, w_cap_nxt;
    logic       r_ack_ph, w_ack_ph_nxt;
    logic       r_rw, w_rw_nxt;
    logic [7:0] w_byte;
    logic [7:0] w_ptr_inc;

    assign w_byte    = {r_shreg[6:0], w_sda_lvl};
    assign w_ptr_inc = (r_ptr == LAST_REG) ? 8'd0 : r_ptr + 8'd1;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 3'd7;
            r_shreg  <= 8'd0;
            r_ptr    <= 8'd0;
            r_wdata  <= 8'd0;
            r_oe     <= 1'b0;
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_cap    <= 1'b0;
            r_ack_ph <= 1'b0;
            r_rw     <= I2C_WRITE;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_ptr    <= w_ptr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_oe     <= w_oe_nxt;
            r_wr_en  <= w_wr_en_nxt;
            r_rd_en  <= w_rd_en_nxt;
            r_cap    <= w_cap_nxt;
            r_ack_ph <= w_ack_ph_nxt;
            r_rw     <= w_rw_nxt;
        end
    end

    // The DEV_ADDR parameter shadows the imported state name, so that state is package-qualified.
    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shreg_nxt  = r_shreg;
        w_ptr_nxt    = r_ptr;
        w_wdata_nxt  = r_wdata;
        w_oe_nxt     = r_oe;
        w_wr_en_nxt  = 1'b0;
        w_rd_en_nxt  = 1'b0;
        w_cap_nxt    = r_rd_en;
        w_ack_ph_nxt = r_ack_ph;
        w_rw_nxt     = r_rw;

        if (r_wr_en) w_ptr_nxt   = w_ptr_inc;
        if (r_cap)   w_shreg_nxt = reg_rdata;

        if (w_start || w_stop) begin
            w_state_nxt  = w_start ? otp_i2c_pkg::DEV_ADDR : IDLE;
            w_cnt_nxt    = 3'd7;
            w_oe_nxt     = 1'b0;
            w_ack_ph_nxt = 1'b0;
        end else begin
            unique case (r_state)
                otp_i2c_pkg::DEV_ADDR, REG_ADDR, WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shreg_nxt = w_byte;
                        if (r_cnt != 3'd0) begin
                            w_cnt_nxt = r_cnt - 3'd1;
                        end else begin
                            w_cnt_nxt    = 3'd7;
                            w_ack_ph_nxt = 1'b0;
                            if (r_state == otp_i2c_pkg::DEV_ADDR) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    w_rw_nxt    = w_byte[0];
                                    w_state_nxt = DEV_ACK;
                                end else begin
                                    w_state_nxt = WAIT_STOP;
                                end
                            end else if (r_state == REG_ADDR) begin
                                if ({1'b0, w_byte} < NUM_REGS_W) begin
                                    w_ptr_nxt   = w_byte;
                                    w_state_nxt = REG_ACK;
                                end else begin
                                    w_state_nxt = WAIT_STOP;
                                end
                            end else begin
                                w_wr_en_nxt = 1'b1;
                                w_wdata_nxt = w_byte;
                                w_state_nxt = WR_ACK;
                            end
                        end
                    end
                end

                // First SCL fall starts the ACK bit, the second one ends it.
                DEV_ACK, REG_ACK, WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_ph) begin
                            w_oe_nxt     = 1'b1;
                            w_ack_ph_nxt = 1'b1;
                        end else begin
                            w_ack_ph_nxt = 1'b0;
                            w_oe_nxt     = 1'b0;
                            if (r_state == DEV_ACK && r_rw == I2C_READ) begin
                                w_state_nxt = RD_DATA;
                                w_oe_nxt    = ~r_shreg[7];
                            end else if (r_state == DEV_ACK) begin
                                w_state_nxt = REG_ADDR;
                            end else begin
                                w_state_nxt = WR_DATA;
                            end
                        end
                    end else if (w_scl_rise && r_ack_ph && r_state == DEV_ACK && r_rw == I2C_READ) begin
                        w_rd_en_nxt = 1'b1;
                    end
                end

                RD_DATA: begin
                    if (w_scl_rise) begin
                        if (r_cnt != 3'd0) begin
                            w_cnt_nxt = r_cnt - 3'd1;
                        end else begin
                            w_cnt_nxt    = 3'd7;
                            w_ack_ph_nxt = 1'b0;
                            w_state_nxt  = RD_ACK;
                        end
                    end else if (w_scl_fall) begin
                        w_shreg_nxt = {r_shreg[6:0], 1'b0};
                        w_oe_nxt    = ~r_shreg[6];
                    end
                end

                RD_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_ack_ph) begin
                            w_oe_nxt     = 1'b0;
                            w_ack_ph_nxt = 1'b1;
                        end else begin
                            w_ack_ph_nxt = 1'b0;
                            w_state_nxt  = RD_DATA;
                            w_oe_nxt     = ~r_shreg[7];
                        end
                    end else if (w_scl_rise && r_ack_ph) begin
                        if (w_sda_lvl == I2C_ACK) begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_rd_en_nxt = 1'b1;
                        end else begin
                            w_ack_ph_nxt = 1'b0;
                            w_state_nxt  = WAIT_STOP;
                        end
                    end
                end

                IDLE, WAIT_STOP: ;

                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign i2c_sda_oe = r_oe;
    assign reg_addr   = r_ptr;
    assign reg_wdata  = r_wdata;
    assign reg_wr_en  = r_wr_en;
    assign reg_rd_en  = r_rd_en;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Self-checking bench: bit-banged I2C master, register-file model and a
// scoreboard of expected register writes and read addresses.
module tb_i2c_slave_regif;
    import otp_i2c_pkg::*;

    localparam int NUM_REGS = 30;
    localparam int Q        = 4;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       m_scl   = 1'b1;
    logic       m_sda   = 1'b1;
    logic       i2c_sda;
    logic       i2c_sda_oe, reg_wr_en, reg_rd_en, busy;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'd0;
    logic [7:0] reg_mem [256];

    assign i2c_sda = m_sda & ~i2c_sda_oe;

    always #5 clk_sys = ~clk_sys;

    i2c_slave_regif #(.NUM_REGS(NUM_REGS)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .i2c_scl    (m_scl),
        .i2c_sda    (i2c_sda),
        .i2c_sda_oe (i2c_sda_oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_en  (reg_rd_en),
        .reg_rdata  (reg_rdata),
        .busy       (busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    logic        oe_seen  = 1'b0;
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk_sys) if (reg_rd_en) reg_rdata <= reg_mem[reg_addr];

    // Scoreboard side: pop expectations as strobes appear on the register port.
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (i2c_sda_oe) oe_seen = 1'b1;
            if (reg_wr_en) begin
                n_writes++;
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wr_unexpected: addr 0x%0h data 0x%0h, no write expected", reg_addr, reg_wdata);
                end else begin
                    check("wr_addr_data", {16'd0, reg_addr, reg_wdata}, {16'd0, wr_q.pop_front()});
                end
            end
            if (reg_rd_en) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: addr 0x%0h, no read expected", reg_addr);
                end else begin
                    check("rd_addr", {24'd0, reg_addr}, {24'd0, rd_q.pop_front()});
                end
            end
        end
    end

    task automatic qwait();
        repeat (Q) @(negedge clk_sys);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait();
        qwait();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    qwait();
        m_scl = 1'b1; qwait(); qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        b = i2c_sda;  qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(mack);
    endtask

    typedef struct packed {
        logic [6:0]       dev;
        logic [7:0]       ptr;
        logic [3:0]       n;
        logic [10:0][7:0] data;
        logic             exp_dev_ack;
        logic             exp_reg_ack;
    } wr_vec_t;

    wr_vec_t vecs [4];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, acc;
        logic [7:0] p, d;
        int         w0;

        vecs[0] = '{dev: 7'h0A, ptr: 8'd18, n: 4'd11,
                    data: {8'hAF, 8'hAE, 8'hAD, 8'hAC, 8'hAB, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA},
                    exp_dev_ack: 1'b1, exp_reg_ack: 1'b1};
        vecs[1] = '{dev: 7'h0B, ptr: 8'd5, n: 4'd1, data: {80'd0, 8'h55},
                    exp_dev_ack: 1'b0, exp_reg_ack: 1'b1};
        vecs[2] = '{dev: 7'h0A, ptr: 8'd29, n: 4'd2, data: {72'd0, 8'h22, 8'h11},
                    exp_dev_ack: 1'b1, exp_reg_ack: 1'b1};
        vecs[3] = '{dev: 7'h0A, ptr: 8'd200, n: 4'd1, data: {80'd0, 8'h77},
                    exp_dev_ack: 1'b1, exp_reg_ack: 1'b0};

        for (int i = 0; i < 256; i++) reg_mem[i] = 8'(i) ^ 8'h5A;
        reg_mem[20] = 8'hCC;
        reg_mem[21] = 8'hDD;

        repeat (3) @(negedge clk_sys);
        check("reset_outputs", {13'd0, i2c_sda_oe, busy, reg_wr_en, reg_rd_en, reg_addr, reg_wdata}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_sys);

        for (int v = 0; v < 4; v++) begin
            oe_seen = 1'b0;
            acc = vecs[v].exp_dev_ack & vecs[v].exp_reg_ack;
            i2c_start();
            write_byte({vecs[v].dev, I2C_WRITE}, ack);
            check($sformatf("v%0d_dev_ack", v), {31'd0, ack}, {31'd0, vecs[v].exp_dev_ack ? I2C_ACK : I2C_NACK});
            write_byte(vecs[v].ptr, ack);
            check($sformatf("v%0d_reg_ack", v), {31'd0, ack}, {31'd0, acc ? I2C_ACK : I2C_NACK});
            p = vecs[v].ptr;
            for (int b = 0; b < int'(vecs[v].n); b++) begin
                if (acc) begin
                    wr_q.push_back({p, vecs[v].data[b]});
                    p = (int'(p) == NUM_REGS - 1) ? 8'd0 : p + 8'd1;
                end
                write_byte(vecs[v].data[b], ack);
                check($sformatf("v%0d_data%0d_ack", v, b), {31'd0, ack}, {31'd0, acc ? I2C_ACK : I2C_NACK});
            end
            i2c_stop();
            repeat (4) @(negedge clk_sys);
            check($sformatf("v%0d_busy_after_stop", v), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_writes_pending", v), wr_q.size(), 32'd0);
            check($sformatf("v%0d_oe_seen", v), {31'd0, oe_seen}, {31'd0, vecs[v].exp_dev_ack});
        end

        // Combined read: set pointer, repeated START, read two bytes.
        w0 = n_writes;
        i2c_start();
        write_byte({I2C_DEV_ADDR, I2C_WRITE}, ack);
        check("rd_dev_w_ack", {31'd0, ack}, {31'd0, I2C_ACK});
        write_byte(8'd20, ack);
        check("rd_reg_ack", {31'd0, ack}, {31'd0, I2C_ACK});
        rd_q.push_back(8'd20);
        rd_q.push_back(8'd21);
        i2c_start();
        write_byte({I2C_DEV_ADDR, I2C_READ}, ack);
        check("rd_dev_r_ack", {31'd0, ack}, {31'd0, I2C_ACK});
        read_byte(I2C_ACK, d);
        check("rd_byte0", {24'd0, d}, 32'hCC);
        read_byte(I2C_NACK, d);
        check("rd_byte1", {24'd0, d}, 32'hDD);
        i2c_stop();
        repeat (4) @(negedge clk_sys);
        check("rd_reads_pending", rd_q.size(), 32'd0);
        check("rd_no_writes", n_writes - w0, 32'd0);
        check("rd_busy_after_stop", {31'd0, busy}, 32'd0);

        // STOP after four data bits discards the partial byte.
        w0 = n_writes;
        i2c_start();
        write_byte({I2C_DEV_ADDR, I2C_WRITE}, ack);
        write_byte(8'd3, ack);
        check("abort_reg_ack", {31'd0, ack}, {31'd0, I2C_ACK});
        for (int i = 0; i < 4; i++) write_bit(i[0]);
        i2c_stop();
        repeat (20) @(negedge clk_sys);
        check("abort_no_writes", n_writes - w0, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);

        // Reset while the slave drives the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(8'({I2C_DEV_ADDR, I2C_WRITE}) >> i);
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        check("rst_pre_oe", {31'd0, i2c_sda_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {13'd0, i2c_sda_oe, busy, reg_wr_en, reg_rd_en, reg_addr, reg_wdata}, 32'd0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (4) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_sys);

        i2c_start();
        write_byte({I2C_DEV_ADDR, I2C_WRITE}, ack);
        check("post_rst_dev_ack", {31'd0, ack}, {31'd0, I2C_ACK});
        write_byte(8'd4, ack);
        check("post_rst_reg_ack", {31'd0, ack}, {31'd0, I2C_ACK});
        wr_q.push_back({8'd4, 8'h5A});
        write_byte(8'h5A, ack);
        check("post_rst_data_ack", {31'd0, ack}, {31'd0, I2C_ACK});
        i2c_stop();
        repeat (4) @(negedge clk_sys);
        check("post_rst_writes_pending", wr_q.size(), 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
